// File: rtl/bnn_pkg.sv
// Shared types and constants for the instruction SRAM loader and its port mux.
package bnn_pkg;

  localparam int unsigned INST_W      = 16;
  localparam int unsigned INST_ADDR_W = 11;
  localparam int unsigned CTRL_W      = 13;
  localparam int unsigned CNT_W       = 12;
  localparam int unsigned MAX_WORDS   = 2048;

  localparam int unsigned CTRL_ADDR_LSB = 0;
  localparam int unsigned CTRL_ADDR_MSB = 10;
  localparam int unsigned CTRL_CEN      = 11;
  localparam int unsigned CTRL_WEN      = 12;

  localparam logic [CTRL_W-1:0] CTRL_IDLE = 13'h1800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Build an SRAM write command (CEN=0, WEN=0) for the given address.
  function automatic logic [CTRL_W-1:0] ctrl_write(input logic [INST_ADDR_W-1:0] addr);
    logic [CTRL_W-1:0] ctrl;
    ctrl = CTRL_IDLE;
    ctrl[CTRL_ADDR_MSB:CTRL_ADDR_LSB] = addr;
    ctrl[CTRL_CEN] = 1'b0;
    ctrl[CTRL_WEN] = 1'b0;
    return ctrl;
  endfunction

  // Clamp a requested load length to the SRAM depth.
  function automatic logic [CNT_W-1:0] sat_len(input logic [CNT_W-1:0] len);
    return (len > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : len;
  endfunction

endpackage

// File: rtl/instsram_port_mux.sv
// Instruction SRAM port owner select: loader write path until RUN, controller afterwards.
module instsram_port_mux
  import bnn_pkg::*;
(
  input  state_t            state,
  input  logic [CTRL_W-1:0] wr_ctrl,
  input  logic [INST_W-1:0] wr_din,
  input  logic [CTRL_W-1:0] ctrl_instsram_ctrl,
  output logic [CTRL_W-1:0] instsram_ctrl,
  output logic [INST_W-1:0] instsram_din
);

  always_comb begin
    instsram_ctrl = wr_ctrl;
    instsram_din  = wr_din;
    if (state == ST_RUN) begin
      instsram_ctrl = ctrl_instsram_ctrl;
      instsram_din  = '0;
    end
  end

endmodule

// File: rtl/inst_sram_loader.sv
// Host-side instruction SRAM writer; holds the BNN controller in reset until the load completes.
// Optional load checksum verification is enabled with INST_SRAM_LOADER_CHECKSUM_EN.
module inst_sram_loader
  import bnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  load_len,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [INST_W-1:0] s_data,
  output logic              s_ready,
  input  logic [CTRL_W-1:0] ctrl_instsram_ctrl,
  output logic [CTRL_W-1:0] instsram_ctrl,
  output logic [INST_W-1:0] instsram_din,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_cnt
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
  ,
  input  logic [INST_W-1:0] exp_sum,
  output logic [INST_W-1:0] checksum,
  output logic              sum_err
`endif
);

  state_t                 state, state_d;
  logic                   s_ready_d;
  logic [CTRL_W-1:0]      wr_ctrl, wr_ctrl_d;
  logic [INST_W-1:0]      wr_din, wr_din_d;
  logic [INST_ADDR_W-1:0] wr_ptr, wr_ptr_d;
  logic [CNT_W-1:0]       word_cnt_d;
  logic [CNT_W-1:0]       target, target_d;
  logic                   hs;
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
  logic [INST_W-1:0]      sum_d, exp_q, exp_d;
  logic                   sum_err_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state and next-register computation; abort overrides everything.
  always_comb begin
    state_d    = state;
    s_ready_d  = 1'b0;
    wr_ctrl_d  = CTRL_IDLE;
    wr_din_d   = wr_din;
    wr_ptr_d   = wr_ptr;
    word_cnt_d = word_cnt;
    target_d   = target;
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
    sum_d      = checksum;
    exp_d      = exp_q;
    sum_err_d  = sum_err;
`endif
    hs = s_valid & s_ready;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_RUN: begin
          if (start) begin
            word_cnt_d = '0;
            wr_ptr_d   = '0;
            target_d   = sat_len(load_len);
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
            sum_d      = '0;
            exp_d      = exp_sum;
            sum_err_d  = 1'b0;
`endif
            if (load_len == '0) begin
              state_d = ST_RUN;
            end else begin
              state_d   = ST_LOAD;
              s_ready_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (hs) begin
            wr_ctrl_d  = ctrl_write(wr_ptr);
            wr_din_d   = s_data;
            word_cnt_d = word_cnt + CNT_W'(1);
            s_ready_d  = (word_cnt_d < target);
            // Pointer stops on the last word so it never wraps past the top address.
            if (s_ready_d) wr_ptr_d = wr_ptr + INST_ADDR_W'(1);
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
            sum_d = checksum + s_data;
`endif
          end else if (word_cnt == target) begin
            // Final write has been driven for a full cycle; hand over the port.
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
            if (checksum == exp_q) begin
              state_d = ST_RUN;
            end else begin
              state_d   = ST_IDLE;
              sum_err_d = 1'b1;
            end
`else
            state_d = ST_RUN;
`endif
          end else begin
            s_ready_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ready  <= 1'b0;
      wr_ctrl  <= CTRL_IDLE;
      wr_din   <= '0;
      wr_ptr   <= '0;
      word_cnt <= '0;
      target   <= '0;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
      checksum <= '0;
      exp_q    <= '0;
      sum_err  <= 1'b0;
`endif
    end else begin
      s_ready  <= s_ready_d;
      wr_ctrl  <= wr_ctrl_d;
      wr_din   <= wr_din_d;
      wr_ptr   <= wr_ptr_d;
      word_cnt <= word_cnt_d;
      target   <= target_d;
      core_rst <= (state_d != ST_RUN);
      busy     <= (state_d == ST_LOAD);
      done     <= (state_d == ST_RUN);
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
      checksum <= sum_d;
      exp_q    <= exp_d;
      sum_err  <= sum_err_d;
`endif
    end
  end

  instsram_port_mux u_port_mux (
    .state              (state),
    .wr_ctrl            (wr_ctrl),
    .wr_din             (wr_din),
    .ctrl_instsram_ctrl (ctrl_instsram_ctrl),
    .instsram_ctrl      (instsram_ctrl),
    .instsram_din       (instsram_din)
  );

endmodule

// File: tb/tb_inst_sram_loader.sv
// Self-checking bench for inst_sram_loader: table-driven loads, write scoreboard, abort and checksum sequences.
module tb_inst_sram_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] load_len;
  logic        abort;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [12:0] ctrl_instsram_ctrl;
  logic [12:0] instsram_ctrl;
  logic [15:0] instsram_din;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic [11:0] word_cnt;
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
  logic [15:0] exp_sum;
  logic [15:0] checksum;
  logic        sum_err;
`endif

  inst_sram_loader dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .load_len           (load_len),
    .abort              (abort),
    .s_valid            (s_valid),
    .s_data             (s_data),
    .s_ready            (s_ready),
    .ctrl_instsram_ctrl (ctrl_instsram_ctrl),
    .instsram_ctrl      (instsram_ctrl),
    .instsram_din       (instsram_din),
    .core_rst           (core_rst),
    .busy               (busy),
    .done               (done),
    .word_cnt           (word_cnt)
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
    ,
    .exp_sum            (exp_sum),
    .checksum           (checksum),
    .sum_err            (sum_err)
`endif
  );

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] din;
  } wr_t;

  typedef struct packed {
    int              len;
    logic            toggle;
    logic            idle_first;
    int              writes;
    int              cycles;
    logic [3:0][15:0] data;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[5];
  int   n_pass;
  int   n_total;
  int   n_writes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [15:0] word_of(input logic [3:0][15:0] d, input int i);
    if (i < 4) return d[i];
    return 16'(i * 37 + 5);
  endfunction

  // Write monitor: every SRAM write must match the next expected scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && !instsram_ctrl[11] && !instsram_ctrl[12]) begin
      wr_t e;
      n_writes++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write addr=%0d din=%0h", instsram_ctrl[10:0], instsram_din);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(instsram_ctrl[10:0]), 32'(e.addr));
        check("write_din", 32'(instsram_din), 32'(e.din));
      end
    end
  end

  // Pulse start, then feed words until the load ends or the cycle budget expires.
  task automatic run_load(input int len, input logic toggle, input logic [3:0][15:0] d,
                          output int cycles);
    int   i;
    logic v;
    @(posedge clk); #1;
    load_len = 12'(len);
    start    = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 0;
    i      = 0;
    while (!done && !(cycles > 0 && !busy) && cycles < 3000) begin
      v       = toggle ? (cycles % 2 == 0) : 1'b1;
      s_data  = word_of(d, i);
      s_valid = v;
      if (v && s_ready) begin
        exp_q.push_back('{addr: 11'(i), din: s_data});
        i++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int w0;
    n_pass = 0; n_total = 0; n_writes = 0;
    rst_n = 1'b0; start = 1'b0; load_len = '0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0; ctrl_instsram_ctrl = 13'h1800;
`ifdef INST_SRAM_LOADER_CHECKSUM_EN
    exp_sum = '0;
`endif

    vecs[0].len = 4;    vecs[0].toggle = 1'b0; vecs[0].idle_first = 1'b1;
    vecs[0].writes = 4; vecs[0].cycles = 5;
    vecs[0].data = {16'h0000, 16'h2103, 16'h0902, 16'h0801};
    vecs[1].len = 3;    vecs[1].toggle = 1'b1; vecs[1].idle_first = 1'b0;
    vecs[1].writes = 3; vecs[1].cycles = 6;
    vecs[1].data = {16'h4444, 16'h3333, 16'hBEEF, 16'hA5A5};
    vecs[2].len = 0;    vecs[2].toggle = 1'b0; vecs[2].idle_first = 1'b1;
    vecs[2].writes = 0; vecs[2].cycles = 0;
    vecs[2].data = {16'h0, 16'h0, 16'h0, 16'h0};
    vecs[3].len = 3000; vecs[3].toggle = 1'b0; vecs[3].idle_first = 1'b0;
    vecs[3].writes = 2048; vecs[3].cycles = 2049;
    vecs[3].data = {16'h0004, 16'h0003, 16'h0002, 16'hFFFF};
    vecs[4].len = 1;    vecs[4].toggle = 1'b0; vecs[4].idle_first = 1'b0;
    vecs[4].writes = 1; vecs[4].cycles = 2;
    vecs[4].data = {16'h0, 16'h0, 16'h0, 16'h7E57};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 32'(instsram_ctrl), 32'h1800);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_din", 32'(instsram_din), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      if (vecs[k].idle_first) begin
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("pre_idle_done", 32'(done), 32'd0);
      end
      w0 = n_writes;
      run_load(vecs[k].len, vecs[k].toggle, vecs[k].data, cycles);
      check($sformatf("v%0d_cycles", k), 32'(cycles), 32'(vecs[k].cycles));
      check($sformatf("v%0d_word_cnt", k), 32'(word_cnt), 32'(vecs[k].writes));
      check($sformatf("v%0d_done", k), 32'(done), 32'd1);
      check($sformatf("v%0d_core_rst", k), 32'(core_rst), 32'd0);
      check($sformatf("v%0d_s_ready", k), 32'(s_ready), 32'd0);
      check($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
      check($sformatf("v%0d_nwrites", k), 32'(n_writes - w0), 32'(vecs[k].writes));
      check($sformatf("v%0d_sb_empty", k), 32'(exp_q.size()), 32'd0);
      if (k == 0) begin
        ctrl_instsram_ctrl = 13'h1005;
        #1;
        check("run_passthru", 32'(instsram_ctrl), 32'h1005);
        check("run_din_zero", 32'(instsram_din), 32'd0);
        ctrl_instsram_ctrl = 13'h1800;
      end
    end

    // Abort after two of five words.
    w0 = n_writes;
    @(posedge clk); #1;
    load_len = 12'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_data  = 16'h1000 + 16'(k);
      s_valid = 1'b1;
      if (s_ready) exp_q.push_back('{addr: 11'(k), din: s_data});
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    abort   = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_core_rst", 32'(core_rst), 32'd1);
    check("abort_word_cnt", 32'(word_cnt), 32'd2);
    check("abort_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("abort_nwrites", 32'(n_writes - w0), 32'd2);
    check("abort_sb_empty", 32'(exp_q.size()), 32'd0);

    // Abort and start together: abort wins.
    abort    = 1'b1;
    start    = 1'b1;
    load_len = 12'd4;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check("abst_busy", 32'(busy), 32'd0);
    check("abst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check("abst_busy_later", 32'(busy), 32'd0);
    check("abst_done", 32'(done), 32'd0);
    check("abst_core_rst", 32'(core_rst), 32'd1);

`ifdef INST_SRAM_LOADER_CHECKSUM_EN
    exp_sum = 16'd6;
    run_load(3, 1'b0, {16'h0, 16'h3, 16'h2, 16'h1}, cycles);
    check("cs_ok_done", 32'(done), 32'd1);
    check("cs_ok_sum", 32'(checksum), 32'd6);
    check("cs_ok_err", 32'(sum_err), 32'd0);
    exp_sum = 16'd7;
    run_load(3, 1'b0, {16'h0, 16'h3, 16'h2, 16'h1}, cycles);
    check("cs_bad_done", 32'(done), 32'd0);
    check("cs_bad_err", 32'(sum_err), 32'd1);
    check("cs_bad_core_rst", 32'(core_rst), 32'd1);
    check("cs_bad_busy", 32'(busy), 32'd0);
    check("cs_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
